// File: rtl/ucdp_afifo_wrarb.sv
`default_nettype none
// ============================================================================
// Module   : ucdp_afifo_wrarb
// Brief    : Round-robin burst arbiter feeding the write side of a FIFO.
// Revision : 1.0
// ============================================================================
module ucdp_afifo_wrarb #(
  parameter int dwidth_p = 8,
  parameter int awidth_p = 4,
  parameter int nreq_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [nreq_p-1:0]            req_valid_i,
  input  logic [nreq_p*awidth_p-1:0]   req_len_i,
  input  logic [nreq_p*dwidth_p-1:0]   req_data_i,
  output logic [nreq_p-1:0]            req_ready_o,
  output logic [nreq_p-1:0]            gnt_o,
  output logic                         busy_o,
  output logic [nreq_p-1:0]            len_err_o,
  input  logic                         fifo_full_i,
  input  logic [awidth_p-1:0]          fifo_space_avail_i,
  output logic                         fifo_wr_en_o,
  output logic [dwidth_p-1:0]          fifo_wr_data_o
);

  localparam int                  IDXW     = (nreq_p > 1) ? $clog2(nreq_p) : 1;
  localparam logic [awidth_p-1:0] DEPTH    = awidth_p'(1) << (awidth_p - 1);
  localparam logic [nreq_p-1:0]   ONE_HOT0 = nreq_p'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [nreq_p-1:0]   gnt_q, gnt_d;
  logic [awidth_p-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0]     rr_q, rr_d;
  logic [IDXW-1:0]     gidx_q, gidx_d;
  logic [nreq_p-1:0]   err_q, err_d;

  logic [awidth_p-1:0] len_arr  [nreq_p];
  logic [dwidth_p-1:0] data_arr [nreq_p];
  logic [nreq_p-1:0]   legal;
  logic [nreq_p-1:0]   eligible;
  logic                found;
  logic [IDXW-1:0]     sel_idx;
  logic [IDXW:0]       cand;
  logic                beat;

  for (genvar i = 0; i < nreq_p; i++) begin : g_unpack
    assign len_arr[i]  = req_len_i[i*awidth_p +: awidth_p];
    assign data_arr[i] = req_data_i[i*dwidth_p +: dwidth_p];
    assign legal[i]    = (len_arr[i] != '0) && (len_arr[i] <= DEPTH);
    assign eligible[i] = req_valid_i[i] & legal[i];
  end

  // Walk the requesters starting at the round-robin pointer; first eligible wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < nreq_p; k++) begin
      cand = {1'b0, rr_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(nreq_p)) begin
        cand = cand - (IDXW+1)'(nreq_p);
      end
      if (!found && eligible[cand[IDXW-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[IDXW-1:0];
      end
    end
  end

  assign beat = req_valid_i[gidx_q] & ~fifo_full_i;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    cnt_d          = cnt_q;
    rr_d           = rr_q;
    gidx_d         = gidx_q;
    err_d          = err_q;
    req_ready_o    = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = '0;
    case (state_q)
      IDLE: begin
        err_d = err_q | (req_valid_i & ~legal);
        // A winner that does not fit waits; lower-priority requesters are not tried.
        if (found && (len_arr[sel_idx] <= fifo_space_avail_i)) begin
          gnt_d   = ONE_HOT0 << sel_idx;
          cnt_d   = len_arr[sel_idx];
          gidx_d  = sel_idx;
          rr_d    = (sel_idx == IDXW'(nreq_p - 1)) ? '0 : sel_idx + 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready_o[gidx_q] = ~fifo_full_i;
        fifo_wr_en_o        = beat;
        fifo_wr_data_o      = data_arr[gidx_q];
        if (beat) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == awidth_p'(1)) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      gidx_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      err_q   <= err_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q == BURST);
  assign len_err_o = err_q;

endmodule
`default_nettype wire

// File: doc/ucdp_afifo_wrarb.md
UCDP_AFIFO_WRARB -- requirements
Module: ucdp_afifo_wrarb

Interface
REQ-001 SHALL have parameter dwidth_p, default 8, FIFO data width.
REQ-002 SHALL have parameter awidth_p, default 4, FIFO pointer width; depth = 2^(awidth_p-1).
REQ-003 SHALL have parameter nreq_p, default 4, number of requesters, legal 2..8.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid_i  input  nreq_p  per-requester beat valid.
REQ-008 SHALL have port req_len_i  input  nreq_p*awidth_p  per-requester burst length in beats; slice i belongs to requester i.
REQ-009 SHALL have port req_data_i  input  nreq_p*dwidth_p  per-requester beat data.
REQ-010 SHALL have port req_ready_o  output  nreq_p  per-requester beat accept.
REQ-011 SHALL have port gnt_o  output  nreq_p  registered one-hot grant.
REQ-012 SHALL have port busy_o  output  1  burst in progress.
REQ-013 SHALL have port len_err_o  output  nreq_p  sticky illegal-length flag per requester.
REQ-014 SHALL have port fifo_full_i  input  1  FIFO write-side full.
REQ-015 SHALL have port fifo_space_avail_i  input  awidth_p  FIFO write-side free entries.
REQ-016 SHALL have port fifo_wr_en_o  output  1  FIFO write enable.
REQ-017 SHALL have port fifo_wr_data_o  output  dwidth_p  FIFO write data.

Function
REQ-018 SHALL implement FSM with states IDLE and BURST; busy_o = (state == BURST).
REQ-019 SHALL treat requester i as eligible when req_valid_i[i]=1 and 1 <= len <= depth.
REQ-020 SHALL set len_err_o[i] when req_valid_i[i]=1 in IDLE and len = 0 or len > depth; the flag stays set until reset and the requester is skipped by arbitration.
REQ-021 SHALL select, in IDLE, the first eligible requester in round-robin order starting at the index after the last grant (index 0 after reset).
REQ-022 SHALL grant the selected requester only if its len <= fifo_space_avail_i; otherwise no grant that cycle and no skip to lower-priority requesters (no starvation of long bursts).
REQ-023 SHALL, on grant, register gnt_o, load the remaining-beat counter with len, update the round-robin pointer and enter BURST on the next edge; req_len_i changes after that edge are ignored.
REQ-024 SHALL in BURST drive req_ready_o[g] = ~fifo_full_i for granted index g, and 0 for all others; all req_ready_o are 0 in IDLE.
REQ-025 SHALL drive fifo_wr_en_o = req_valid_i[g] & req_ready_o[g] and fifo_wr_data_o = req_data_i[g] combinationally in BURST; both 0 in IDLE.
REQ-026 SHALL decrement the counter on each accepted beat; on acceptance with counter = 1 it SHALL clear gnt_o and return to IDLE on the next edge.
REQ-027 SHALL hold the counter and grant while req_valid_i[g]=0 or fifo_full_i=1 (no timeout, no abort).
REQ-028 SHALL spend at least one IDLE cycle between bursts; a stall-free burst of L beats occupies L+1 cycles from arbitration.
REQ-029 SHALL never assert fifo_wr_en_o while fifo_full_i=1.

Reset
REQ-030 SHALL on rst_i=1 at a clock edge force IDLE, gnt_o=0, counter=0, round-robin pointer to index 0, len_err_o=0; req_ready_o, fifo_wr_en_o, fifo_wr_data_o, busy_o are 0 from the next cycle.
REQ-031 SHALL abandon any burst in progress on reset; beats not yet accepted are not written.

Verification (nreq_p=4, awidth_p=4, depth=8)
REQ-032 SHALL verify: rst_i=1 for 2 cycles mid-burst -> all outputs 0 next cycle, next grant goes to requester 0.
REQ-033 SHALL verify: req0 valid, len=3, space=8, full=0 -> gnt_o=0001 one cycle later, 3 consecutive fifo_wr_en_o beats with req0 data in order, then busy_o=0.
REQ-034 SHALL verify: all four valid, len=1, continuously -> grants 0,1,2,3,0, each 2 cycles apart.
REQ-035 SHALL verify: req1 len=5, req2 len=1, space=4 -> no grant; space raised to 5 -> gnt_o=0010, req2 served afterwards.
REQ-036 SHALL verify: len=4 burst, fifo_full_i=1 for 2 cycles after beat 2 -> ready and wr_en 0 for those cycles, exactly 4 beats written in total.
REQ-037 SHALL verify: req0 len=0, req1 len=2 -> len_err_o=0001 sticky, gnt_o=0010, 2 beats written.
